// File: rtl/mfcc_melbank_rom_reader.sv
// -----------------------------------------------------------------------------
// mfcc_melbank_rom_reader
//
// Purpose:
//   Client side of the melbank weight ROM. Converts a stream of power-spectrum
//   bins into mel-band energies. For bin k the ROM is addressed with k and
//   returns {f, w}. Each bin then contributes:
//     - pwr*w               to band f-1
//     - pwr*(2^W_WIDTH - w) to band f
//   Two running accumulators hold the two open bands (acc_lo = band f_cur-1,
//   acc_hi = band f_cur). When the ROM band field advances by one, band f_cur-1
//   is complete and is handed to the output register.
//   ROM_LATENCY (0 or 1) selects whether an extra wait cycle is inserted for a
//   registered ROM output.
//
// Configuration macro:
//   MELBANK_SAT_EN - when defined, accumulators saturate at 2**ACC_WIDTH-1 and
//                    err pulses once on the first saturation in a frame. When
//                    undefined, accumulators wrap modulo 2**ACC_WIDTH.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   s_valid   in   input bin valid
//   s_ready   out  input bin accepted when s_valid & s_ready
//   s_data    in   bin power (PWR_WIDTH, unsigned)
//   s_last    in   last bin of frame
//   rom_addr  out  ROM address (bin index)
//   rom_data  in   ROM word {f[BAND_WIDTH-1:0], w[W_WIDTH-1:0]}
//   m_valid   out  band result valid
//   m_ready   in   downstream accepts band
//   m_data    out  band energy, W_WIDTH fractional bits
//   m_band    out  band index 0..BAND_NUM-1
//   m_last    out  last band of frame
//   err       out  one-cycle pulse: band jump, bin overflow, empty frame
//                  (or first saturation when MELBANK_SAT_EN is defined)
// -----------------------------------------------------------------------------
module mfcc_melbank_rom_reader #(
  parameter int ADDR_WIDTH  = 9,
  parameter int W_WIDTH     = 15,
  parameter int BAND_WIDTH  = 5,
  parameter int BAND_NUM    = 26,
  parameter int PWR_WIDTH   = 32,
  parameter int ACC_WIDTH   = 48,
  parameter int ROM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [PWR_WIDTH-1:0]          s_data,
  input  logic                          s_last,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [BAND_WIDTH+W_WIDTH-1:0] rom_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [ACC_WIDTH-1:0]          m_data,
  output logic [BAND_WIDTH-1:0]         m_band,
  output logic                          m_last,
  output logic                          err
);

  localparam int PROD_W = PWR_WIDTH + W_WIDTH + 1;
  localparam logic [BAND_WIDTH:0] BAND_NUM_L = (BAND_WIDTH + 1)'(BAND_NUM);
  localparam logic [W_WIDTH:0]    FULL_W     = {1'b1, {W_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MAC,
    S_EMIT,
    S_FLUSH
  } state_t;

  state_t                  state_q, state_d;
  logic [PWR_WIDTH-1:0]    pwr_q, pwr_d;
  logic                    last_q, last_d;
  logic [ADDR_WIDTH-1:0]   bin_cnt_q, bin_cnt_d;
  logic [BAND_WIDTH-1:0]   f_cur_q, f_cur_d;
  logic [ACC_WIDTH-1:0]    acc_lo_q, acc_lo_d;
  logic [ACC_WIDTH-1:0]    acc_hi_q, acc_hi_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic                    s_ready_q;
  logic                    m_valid_q;
  logic [ACC_WIDTH-1:0]    m_data_q, m_data_d;
  logic [BAND_WIDTH-1:0]   m_band_q, m_band_d;
  logic                    m_last_q, m_last_d;
  logic                    err_q, err_d;
  logic [1:0]              flush_ph_q, flush_ph_d;
  logic                    frame_emit_q, frame_emit_d;

  // ROM word fields and band relations
  logic [BAND_WIDTH-1:0]   rom_f;
  logic [W_WIDTH-1:0]      rom_w;
  logic [W_WIDTH:0]        w_comp;
  logic [BAND_WIDTH:0]     f_cur_ext;
  logic                    f_match;
  logic                    f_step;
  logic                    lo_ok;
  logic                    hi_ok;

  // Arithmetic
  logic [PROD_W-1:0]       prod_lo;
  logic [PROD_W-1:0]       prod_hi;
  logic [ACC_WIDTH-1:0]    base_lo;
  logic [ACC_WIDTH-1:0]    base_hi;
  logic [ACC_WIDTH-1:0]    new_lo;
  logic [ACC_WIDTH-1:0]    new_hi;

  assign rom_f     = rom_data[BAND_WIDTH+W_WIDTH-1 -: BAND_WIDTH];
  assign rom_w     = rom_data[W_WIDTH-1:0];
  assign w_comp    = FULL_W - {1'b0, rom_w};
  assign f_cur_ext = {1'b0, f_cur_q};
  assign f_match   = (rom_f == f_cur_q);
  // Extended compare so f_cur at the top of its range never aliases to 0.
  assign f_step    = ({1'b0, rom_f} == f_cur_ext + (BAND_WIDTH + 1)'(1));
  // Band f_cur-1 is emittable only when it exists and is below BAND_NUM.
  assign lo_ok     = (f_cur_q != '0) && (f_cur_ext <= BAND_NUM_L);
  assign hi_ok     = (f_cur_ext < BAND_NUM_L);

  assign prod_lo   = PROD_W'(pwr_q) * PROD_W'(rom_w);
  assign prod_hi   = PROD_W'(pwr_q) * PROD_W'(w_comp);

  // On a band step the old acc_lo leaves, acc_hi becomes the new lower band
  // and the new upper band starts from zero before this bin is added.
  assign base_lo   = f_step ? acc_hi_q : acc_lo_q;
  assign base_hi   = f_step ? '0 : acc_hi_q;

`ifdef MELBANK_SAT_EN
  localparam int SUM_W = ((PROD_W > ACC_WIDTH) ? PROD_W : ACC_WIDTH) + 1;
  logic [SUM_W-1:0] sum_lo;
  logic [SUM_W-1:0] sum_hi;
  logic             ovf_lo;
  logic             ovf_hi;
  logic             sat_seen_q, sat_seen_d;

  assign sum_lo = SUM_W'(base_lo) + SUM_W'(prod_lo);
  assign sum_hi = SUM_W'(base_hi) + SUM_W'(prod_hi);
  assign ovf_lo = |sum_lo[SUM_W-1:ACC_WIDTH];
  assign ovf_hi = |sum_hi[SUM_W-1:ACC_WIDTH];
  // Clamping to all-ones is naturally sticky: any further add overflows again.
  assign new_lo = ovf_lo ? '1 : sum_lo[ACC_WIDTH-1:0];
  assign new_hi = ovf_hi ? '1 : sum_hi[ACC_WIDTH-1:0];
`else
  assign new_lo = base_lo + ACC_WIDTH'(prod_lo);
  assign new_hi = base_hi + ACC_WIDTH'(prod_hi);
`endif

  always_comb begin
    state_d      = state_q;
    pwr_d        = pwr_q;
    last_d       = last_q;
    bin_cnt_d    = bin_cnt_q;
    f_cur_d      = f_cur_q;
    acc_lo_d     = acc_lo_q;
    acc_hi_d     = acc_hi_q;
    rom_addr_d   = rom_addr_q;
    m_data_d     = m_data_q;
    m_band_d     = m_band_q;
    m_last_d     = m_last_q;
    flush_ph_d   = flush_ph_q;
    frame_emit_d = frame_emit_q;
    err_d        = 1'b0;
`ifdef MELBANK_SAT_EN
    sat_seen_d   = sat_seen_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (s_valid && s_ready_q) begin
          pwr_d      = s_data;
          rom_addr_d = bin_cnt_q;
          bin_cnt_d  = s_last ? '0 : bin_cnt_q + ADDR_WIDTH'(1);
          // Address space exhausted without s_last: close the frame here.
          if (bin_cnt_q == '1 && !s_last) begin
            err_d  = 1'b1;
            last_d = 1'b1;
          end else begin
            last_d = s_last;
          end
          state_d = (ROM_LATENCY != 0) ? S_WAIT : S_MAC;
        end
      end

      S_WAIT: begin
        state_d = S_MAC;
      end

      S_MAC: begin
        state_d = last_q ? S_FLUSH : S_IDLE;
        if (f_match || f_step) begin
          acc_lo_d = new_lo;
          acc_hi_d = new_hi;
`ifdef MELBANK_SAT_EN
          if ((ovf_lo || ovf_hi) && !sat_seen_q) begin
            err_d      = 1'b1;
            sat_seen_d = 1'b1;
          end
`endif
          if (f_step) begin
            f_cur_d = rom_f;
            if (lo_ok) begin
              m_data_d     = acc_lo_q;
              m_band_d     = f_cur_q - BAND_WIDTH'(1);
              m_last_d     = 1'b0;
              frame_emit_d = 1'b1;
              state_d      = S_EMIT;
            end
          end
        end else begin
          // Band field jumped or went backwards: drop the bin. A dropped last
          // bin still closes the frame.
          err_d = 1'b1;
        end
      end

      S_EMIT: begin
        if (m_ready) begin
          state_d = last_q ? S_FLUSH : S_IDLE;
        end
      end

      S_FLUSH: begin
        case (flush_ph_q)
          2'd0: begin
            flush_ph_d = 2'd1;
            if (lo_ok) begin
              m_data_d     = acc_lo_q;
              m_band_d     = f_cur_q - BAND_WIDTH'(1);
              m_last_d     = !hi_ok;
              frame_emit_d = 1'b1;
              state_d      = S_EMIT;
            end
          end
          2'd1: begin
            flush_ph_d = 2'd2;
            if (hi_ok) begin
              m_data_d     = acc_hi_q;
              m_band_d     = f_cur_q;
              m_last_d     = 1'b1;
              frame_emit_d = 1'b1;
              state_d      = S_EMIT;
            end
          end
          default: begin
            if (!frame_emit_q) begin
              err_d = 1'b1;
            end
            f_cur_d      = '0;
            bin_cnt_d    = '0;
            acc_lo_d     = '0;
            acc_hi_d     = '0;
            last_d       = 1'b0;
            flush_ph_d   = 2'd0;
            frame_emit_d = 1'b0;
`ifdef MELBANK_SAT_EN
            sat_seen_d   = 1'b0;
`endif
            state_d      = S_IDLE;
          end
        endcase
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pwr_q        <= '0;
      last_q       <= 1'b0;
      bin_cnt_q    <= '0;
      f_cur_q      <= '0;
      acc_lo_q     <= '0;
      acc_hi_q     <= '0;
      rom_addr_q   <= '0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_band_q     <= '0;
      m_last_q     <= 1'b0;
      err_q        <= 1'b0;
      flush_ph_q   <= 2'd0;
      frame_emit_q <= 1'b0;
`ifdef MELBANK_SAT_EN
      sat_seen_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pwr_q        <= pwr_d;
      last_q       <= last_d;
      bin_cnt_q    <= bin_cnt_d;
      f_cur_q      <= f_cur_d;
      acc_lo_q     <= acc_lo_d;
      acc_hi_q     <= acc_hi_d;
      rom_addr_q   <= rom_addr_d;
      // Handshake flags are registered from the next state so they line up
      // with the state register and come out of reset low.
      s_ready_q    <= (state_d == S_IDLE);
      m_valid_q    <= (state_d == S_EMIT);
      m_data_q     <= m_data_d;
      m_band_q     <= m_band_d;
      m_last_q     <= m_last_d;
      err_q        <= err_d;
      flush_ph_q   <= flush_ph_d;
      frame_emit_q <= frame_emit_d;
`ifdef MELBANK_SAT_EN
      sat_seen_q   <= sat_seen_d;
`endif
    end
  end

  assign s_ready  = s_ready_q;
  assign rom_addr = rom_addr_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_band   = m_band_q;
  assign m_last   = m_last_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mfcc_melbank_rom_reader.sv
// -----------------------------------------------------------------------------
// tb_mfcc_melbank_rom_reader
//
// Directed bench for mfcc_melbank_rom_reader with a registered ROM model
// (ROM_LATENCY=1) and ACC_WIDTH=40. A negedge monitor records every
// handshaked band and counts err pulses; each test task compares what was
// recorded during its frame against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mfcc_melbank_rom_reader;

  localparam int AW = 9;
  localparam int WW = 15;
  localparam int BW = 5;
  localparam int BN = 26;
  localparam int PW = 32;
  localparam int AC = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [PW-1:0]     s_data;
  logic              s_last;
  logic [AW-1:0]     rom_addr;
  logic [BW+WW-1:0]  rom_data;
  logic              m_valid;
  logic              m_ready;
  logic [AC-1:0]     m_data;
  logic [BW-1:0]     m_band;
  logic              m_last;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mfcc_melbank_rom_reader #(
    .ADDR_WIDTH (AW),
    .W_WIDTH    (WW),
    .BAND_WIDTH (BW),
    .BAND_NUM   (BN),
    .PWR_WIDTH  (PW),
    .ACC_WIDTH  (AC),
    .ROM_LATENCY(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_band  (m_band),
    .m_last  (m_last),
    .err     (err)
  );

  // Registered ROM model
  logic [BW-1:0] rom_f [512];
  logic [WW-1:0] rom_w [512];
  always @(posedge clk) rom_data <= {rom_f[rom_addr], rom_w[rom_addr]};

  // Output monitor
  logic [AC-1:0] q_data [$];
  logic [BW-1:0] q_band [$];
  logic          q_last [$];
  int            err_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_band.push_back(m_band);
        q_last.push_back(m_last);
        $display("band %0d data=%0d last=%0b", m_band, m_data, m_last);
      end
      if (err) err_cnt++;
    end
  end

  task automatic fill_rom(input logic [BW-1:0] f, input logic [WW-1:0] w);
    for (int i = 0; i < 512; i++) begin
      rom_f[i] = f;
      rom_w[i] = w;
    end
  endtask

  task automatic send_bin(input logic [PW-1:0] pwr, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = pwr;
    s_last  = last;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL send_bin accept: got s_ready=0 after %0d cycles, expected 1", n);
    end else begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    int qb;
    int eb;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_band !== '0 ||
        m_last !== 1'b0 || err !== 1'b0 || rom_addr !== '0) begin
      errors++;
      $display("FAIL reset_init: got s_ready=%0b m_valid=%0b m_data=%0d m_band=%0d m_last=%0b err=%0b rom_addr=%0d expected all 0",
               s_ready, m_valid, m_data, m_band, m_last, err, rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fill_rom(5'd1, 15'd0);
    qb = q_data.size();
    eb = err_cnt;
    for (int i = 0; i < 4; i++) send_bin(32'd5, 1'b0);
    // Fourth bin now in WAIT; step into MAC and reset there.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_band !== '0 ||
        m_last !== 1'b0 || err !== 1'b0 || rom_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid_mac: got s_ready=%0b m_valid=%0b m_data=%0d m_band=%0d m_last=%0b err=%0b rom_addr=%0d expected all 0",
               s_ready, m_valid, m_data, m_band, m_last, err, rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_bin(32'd7, 1'b1);
    checks++;
    if (rom_addr !== '0) begin
      errors++;
      $display("FAIL reset_first_addr: got %0d expected 0", rom_addr);
    end
    drain();
    checks++;
    if (q_data.size() - qb != 2) begin
      errors++;
      $display("FAIL reset_count: got %0d bands expected 2", q_data.size() - qb);
    end else begin
      checks++;
      if (q_band[qb] !== 5'd0 || q_data[qb] !== 40'd0 || q_last[qb] !== 1'b0) begin
        errors++;
        $display("FAIL reset_band0: got band=%0d data=%0d last=%0b expected band=0 data=0 last=0",
                 q_band[qb], q_data[qb], q_last[qb]);
      end
      checks++;
      if (q_band[qb+1] !== 5'd1 || q_data[qb+1] !== 40'(7 * 32768) || q_last[qb+1] !== 1'b1) begin
        errors++;
        $display("FAIL reset_band1: got band=%0d data=%0d last=%0b expected band=1 data=%0d last=1",
                 q_band[qb+1], q_data[qb+1], q_last[qb+1], 7 * 32768);
      end
    end
    checks++;
    if (err_cnt - eb != 0) begin
      errors++;
      $display("FAIL reset_err: got %0d err pulses expected 0", err_cnt - eb);
    end
  endtask

  // f=1 everywhere, w=2^14, four bins of power 4.
  task automatic test_single_band();
    int qb = q_data.size();
    int eb = err_cnt;
    logic [AC-1:0] ed [2];
    logic [BW-1:0] ebd [2];
    logic          el [2];
    fill_rom(5'd1, 15'h4000);
    for (int i = 0; i < 4; i++) send_bin(32'd4, i == 3);
    drain();
    ed[0] = 40'(4 * 4 * 16384);            ebd[0] = 5'd0; el[0] = 1'b0;
    ed[1] = 40'(4 * 4 * (32768 - 16384));  ebd[1] = 5'd1; el[1] = 1'b1;
    checks++;
    if (q_data.size() - qb != 2) begin
      errors++;
      $display("FAIL single_band count: got %0d expected 2", q_data.size() - qb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (q_band[qb+i] !== ebd[i] || q_data[qb+i] !== ed[i] || q_last[qb+i] !== el[i]) begin
          errors++;
          $display("FAIL single_band item%0d: got band=%0d data=%0d last=%0b expected band=%0d data=%0d last=%0b",
                   i, q_band[qb+i], q_data[qb+i], q_last[qb+i], ebd[i], ed[i], el[i]);
        end
      end
    end
    checks++;
    if (err_cnt - eb != 0) begin
      errors++;
      $display("FAIL single_band err: got %0d expected 0", err_cnt - eb);
    end
  endtask

  // f steps 1,1,2 with w=0 and power 8.
  task automatic test_band_step();
    int qb = q_data.size();
    int eb = err_cnt;
    logic [AC-1:0] ed [3];
    logic [BW-1:0] ebd [3];
    logic          el [3];
    fill_rom(5'd1, 15'd0);
    rom_f[2] = 5'd2;
    for (int i = 0; i < 3; i++) send_bin(32'd8, i == 2);
    drain();
    ed[0] = 40'd0;             ebd[0] = 5'd0; el[0] = 1'b0;
    ed[1] = 40'(2 * 8 * 32768); ebd[1] = 5'd1; el[1] = 1'b0;
    ed[2] = 40'(8 * 32768);     ebd[2] = 5'd2; el[2] = 1'b1;
    checks++;
    if (q_data.size() - qb != 3) begin
      errors++;
      $display("FAIL band_step count: got %0d expected 3", q_data.size() - qb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_band[qb+i] !== ebd[i] || q_data[qb+i] !== ed[i] || q_last[qb+i] !== el[i]) begin
          errors++;
          $display("FAIL band_step item%0d: got band=%0d data=%0d last=%0b expected band=%0d data=%0d last=%0b",
                   i, q_band[qb+i], q_data[qb+i], q_last[qb+i], ebd[i], ed[i], el[i]);
        end
      end
    end
    checks++;
    if (err_cnt - eb != 0) begin
      errors++;
      $display("FAIL band_step err: got %0d expected 0", err_cnt - eb);
    end
  endtask

  // f = 1,2,2 with w=2^14, power 8; m_ready held low during the mid-frame emit.
  task automatic test_backpressure();
    int qb = q_data.size();
    int n = 0;
    logic [AC-1:0] ed [3];
    logic [BW-1:0] ebd [3];
    logic          el [3];
    fill_rom(5'd1, 15'h4000);
    rom_f[1] = 5'd2;
    rom_f[2] = 5'd2;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    send_bin(32'd8, 1'b0);
    send_bin(32'd8, 1'b0);
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure emit: got m_valid=%0b expected 1", m_valid);
    end
    s_valid = 1'b1;
    s_data  = 32'd8;
    s_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 40'd131072 || m_band !== 5'd0 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold%0d: got m_valid=%0b m_data=%0d m_band=%0d s_ready=%0b expected 1 131072 0 0",
                 i, m_valid, m_data, m_band, s_ready);
      end
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send_bin(32'd8, 1'b1);
    drain();
    ed[0] = 40'(8 * 16384);     ebd[0] = 5'd0; el[0] = 1'b0;
    ed[1] = 40'(3 * 8 * 16384); ebd[1] = 5'd1; el[1] = 1'b0;
    ed[2] = 40'(2 * 8 * 16384); ebd[2] = 5'd2; el[2] = 1'b1;
    checks++;
    if (q_data.size() - qb != 3) begin
      errors++;
      $display("FAIL backpressure count: got %0d expected 3", q_data.size() - qb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_band[qb+i] !== ebd[i] || q_data[qb+i] !== ed[i] || q_last[qb+i] !== el[i]) begin
          errors++;
          $display("FAIL backpressure item%0d: got band=%0d data=%0d last=%0b expected band=%0d data=%0d last=%0b",
                   i, q_band[qb+i], q_data[qb+i], q_last[qb+i], ebd[i], ed[i], el[i]);
        end
      end
    end
  endtask

  // f = 1,3,1 with w=0: the jumping bin (power 100) must vanish.
  task automatic test_jump();
    int qb = q_data.size();
    int eb = err_cnt;
    fill_rom(5'd1, 15'd0);
    rom_f[1] = 5'd3;
    send_bin(32'd8, 1'b0);
    send_bin(32'd100, 1'b0);
    send_bin(32'd8, 1'b1);
    drain();
    checks++;
    if (err_cnt - eb != 1) begin
      errors++;
      $display("FAIL jump err: got %0d pulses expected 1", err_cnt - eb);
    end
    checks++;
    if (q_data.size() - qb != 2) begin
      errors++;
      $display("FAIL jump count: got %0d expected 2", q_data.size() - qb);
    end else begin
      checks++;
      if (q_band[qb] !== 5'd0 || q_data[qb] !== 40'd0 || q_last[qb] !== 1'b0) begin
        errors++;
        $display("FAIL jump band0: got band=%0d data=%0d last=%0b expected band=0 data=0 last=0",
                 q_band[qb], q_data[qb], q_last[qb]);
      end
      checks++;
      if (q_band[qb+1] !== 5'd1 || q_data[qb+1] !== 40'(2 * 8 * 32768) || q_last[qb+1] !== 1'b1) begin
        errors++;
        $display("FAIL jump band1: got band=%0d data=%0d last=%0b expected band=1 data=%0d last=1",
                 q_band[qb+1], q_data[qb+1], q_last[qb+1], 2 * 8 * 32768);
      end
    end
  endtask

  // 512 bins without s_last: the last address forces the frame closed.
  task automatic test_overflow();
    int qb = q_data.size();
    int eb = err_cnt;
    fill_rom(5'd1, 15'd0);
    for (int i = 0; i < 512; i++) send_bin(32'd1, 1'b0);
    drain();
    checks++;
    if (err_cnt - eb != 1) begin
      errors++;
      $display("FAIL overflow err: got %0d pulses expected 1", err_cnt - eb);
    end
    checks++;
    if (q_data.size() - qb != 2) begin
      errors++;
      $display("FAIL overflow count: got %0d expected 2", q_data.size() - qb);
    end else begin
      checks++;
      if (q_band[qb+1] !== 5'd1 || q_data[qb+1] !== 40'(512 * 32768) || q_last[qb+1] !== 1'b1) begin
        errors++;
        $display("FAIL overflow band1: got band=%0d data=%0d last=%0b expected band=1 data=%0d last=1",
                 q_band[qb+1], q_data[qb+1], q_last[qb+1], 512 * 32768);
      end
    end
  endtask

  // 512 bins of full power with w=2^15-1 into 40-bit accumulators.
  task automatic test_saturation();
    int qb = q_data.size();
    int eb = err_cnt;
    logic [63:0] p_lo;
    logic [63:0] p_hi;
    logic [AC-1:0] e0;
    logic [AC-1:0] e1;
    int e_err;
    p_lo = 64'h0000_0000_FFFF_FFFF * 64'd32767;
    p_hi = 64'h0000_0000_FFFF_FFFF;
`ifdef MELBANK_SAT_EN
    e0    = {AC{1'b1}};
    e1    = {AC{1'b1}};
    e_err = 1;
`else
    e0    = AC'(p_lo * 64'd512);
    e1    = AC'(p_hi * 64'd512);
    e_err = 0;
`endif
    fill_rom(5'd1, 15'h7FFF);
    for (int i = 0; i < 512; i++) send_bin(32'hFFFF_FFFF, i == 511);
    drain();
    checks++;
    if (err_cnt - eb != e_err) begin
      errors++;
      $display("FAIL saturation err: got %0d pulses expected %0d", err_cnt - eb, e_err);
    end
    checks++;
    if (q_data.size() - qb != 2) begin
      errors++;
      $display("FAIL saturation count: got %0d expected 2", q_data.size() - qb);
    end else begin
      checks++;
      if (q_data[qb] !== e0) begin
        errors++;
        $display("FAIL saturation band0: got %0d expected %0d", q_data[qb], e0);
      end
      checks++;
      if (q_data[qb+1] !== e1) begin
        errors++;
        $display("FAIL saturation band1: got %0d expected %0d", q_data[qb+1], e1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    fill_rom(5'd0, 15'd0);
    repeat (3) @(negedge clk);
    test_reset();
    test_single_band();
    test_band_step();
    test_backpressure();
    test_jump();
    test_overflow();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
